// File: rtl/clk_int_div_glitch_free.sv
// Glitch-free integer clock divider: bypass for N<2, 50% duty for even and odd N,
// with a handshaked divisor change that gates clk_o low around the switch.

module tc_clk_and2 (
  input  logic clk0_i,
  input  logic clk1_i,
  output logic clk_o
);
  assign clk_o = clk0_i & clk1_i;
endmodule

module tc_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);
  assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

module tc_clk_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic en_latch;

  // Enable only passes while the clock is low, so the output never chops a high phase.
  always_latch begin
    if (!clk_i) en_latch <= en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latch;
endmodule

module clk_int_div_glitch_free #(
  parameter int unsigned DIV_WIDTH   = 4,
  parameter int unsigned DEFAULT_DIV = 1,
  parameter int unsigned GATE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 test_mode_en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 clk_o,
  output logic [DIV_WIDTH-1:0] cycl_count_o
);
  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, WAIT_END, GATE, APPLY} state_e;

  state_e               state_q;
  logic [DIV_WIDTH-1:0] div_q, div_pend_q, cnt_q, cnt_d, half;
  logic [GW-1:0]        gcnt_q;
  logic                 ready_q, sw_gate_q, en_gate_q, stopped_q;
  logic                 t_pos_q, t_pos_d, t_neg_q;
  logic                 bypass, at_end, stop_now, cnt_clr;
  logic                 div_odd_clk, div_clk, mux_clk, gated_clk, gate_en;

  assign bypass   = div_q < DIV_WIDTH'(2);
  assign half     = div_q >> 1;
  assign at_end   = !bypass && (cnt_q == div_q - 1'b1);
  assign stop_now = !stopped_q && !en_i && (bypass || at_end);
  // Counter and t_pos are held at zero whenever the divided clock must stay low.
  assign cnt_clr  = bypass || stopped_q || stop_now || (state_q == GATE) || (state_q == APPLY);

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    t_pos_d = 1'b0;
    if (cnt_clr) begin
      cnt_d = '0;
    end else begin
      if (at_end) cnt_d = '0;
      t_pos_d = div_q[0] ? (cnt_q <= half) : (cnt_q < half);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      div_pend_q <= '0;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      t_pos_q    <= 1'b0;
      ready_q    <= 1'b0;
      sw_gate_q  <= 1'b1;
      en_gate_q  <= 1'b0;
      stopped_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      t_pos_q <= t_pos_d;

      if (stopped_q) begin
        if (en_i) begin
          stopped_q <= 1'b0;
          en_gate_q <= 1'b1;
        end
      end else if (stop_now) begin
        stopped_q <= 1'b1;
        en_gate_q <= 1'b0;
      end

      case (state_q)
        RUN: begin
          if (div_valid_i && ready_q) begin
            div_pend_q <= div_i;
            ready_q    <= 1'b0;
            state_q    <= WAIT_END;
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT_END: begin
          if (div_pend_q == div_q) begin
            ready_q <= 1'b1;
            state_q <= RUN;
          end else if (bypass || stopped_q || at_end) begin
            sw_gate_q <= 1'b0;
            gcnt_q    <= '0;
            state_q   <= GATE;
          end
        end
        GATE: begin
          if (gcnt_q == GW'(GATE_CYCLES - 1)) begin
            div_q   <= div_pend_q;
            state_q <= APPLY;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: begin
          // Gate reopens one cycle after the mux moved, while the new source is still low.
          sw_gate_q <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= RUN;
        end
      endcase
    end
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) t_neg_q <= 1'b0;
    else       t_neg_q <= t_pos_q;
  end

  assign gate_en = sw_gate_q & en_gate_q;

  tc_clk_and2 u_and_odd (
    .clk0_i (t_pos_q),
    .clk1_i (t_neg_q),
    .clk_o  (div_odd_clk)
  );

  tc_clk_mux2 u_mux_parity (
    .clk0_i    (t_pos_q),
    .clk1_i    (div_odd_clk),
    .clk_sel_i (div_q[0]),
    .clk_o     (div_clk)
  );

  tc_clk_mux2 u_mux_mode (
    .clk0_i    (div_clk),
    .clk1_i    (clk_i),
    .clk_sel_i (bypass),
    .clk_o     (mux_clk)
  );

  tc_clk_gating u_gate (
    .clk_i     (mux_clk),
    .en_i      (gate_en),
    .test_en_i (1'b0),
    .clk_o     (gated_clk)
  );

  tc_clk_mux2 u_mux_test (
    .clk0_i    (gated_clk),
    .clk1_i    (clk_i),
    .clk_sel_i (test_mode_en_i),
    .clk_o     (clk_o)
  );

  assign div_ready_o  = ready_q;
  assign cycl_count_o = cnt_q;
endmodule

// File: tb/tb_clk_int_div_glitch_free.sv
// Directed bench for clk_int_div_glitch_free: every clk_i cycle checks clk_o in both
// clock phases and the phase counter against hand-derived waveforms.

module tb_clk_int_div_glitch_free;
  logic       clk_i = 1'b0;
  logic       rst_i, en_i, test_mode_en_i, div_valid_i;
  logic [3:0] div_i;
  logic       div_ready_o, clk_o;
  logic [3:0] cycl_count_o;
  int         checks = 0;
  int         errors = 0;

  clk_int_div_glitch_free #(.DIV_WIDTH(4), .DEFAULT_DIV(1), .GATE_CYCLES(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .test_mode_en_i (test_mode_en_i),
    .div_i          (div_i),
    .div_valid_i    (div_valid_i),
    .div_ready_o    (div_ready_o),
    .clk_o          (clk_o),
    .cycl_count_o   (cycl_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clk_i cycle: clk_o just after the rising edge, counter, clk_o just after the falling edge.
  task automatic cyc(input int e, input logic ep, input logic en, input int ec);
    @(posedge clk_i); #1;
    chk($sformatf("E%0d_clk_hi", e), {31'd0, clk_o}, {31'd0, ep});
    chk($sformatf("E%0d_cnt", e), {28'd0, cycl_count_o}, ec);
    @(negedge clk_i); #1;
    chk($sformatf("E%0d_clk_lo", e), {31'd0, clk_o}, {31'd0, en});
  endtask

  task automatic ready_is(input int e, input logic exp);
    chk($sformatf("E%0d_ready", e), {31'd0, div_ready_o}, {31'd0, exp});
  endtask

  task automatic request(input logic [3:0] d);
    div_i = d;
    div_valid_i = 1'b1;
    $display("request div=%0d at t=%0t", d, $time);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; test_mode_en_i = 1'b0; div_valid_i = 1'b0; div_i = 4'd0;
    repeat (2) @(posedge clk_i);
    cyc(3, 0, 0, 0); ready_is(3, 0);
    rst_i = 1'b0;
    cyc(4, 0, 0, 0); ready_is(4, 1);
    cyc(5, 1, 0, 0);
    // bypass -> 4; a different request held during the switch must be ignored
    request(4'd4);
    cyc(6, 1, 0, 0); ready_is(6, 0);
    div_i = 4'd7;
    cyc(7, 1, 0, 0);
    cyc(8, 0, 0, 0);
    cyc(9, 0, 0, 0); div_valid_i = 1'b0;
    cyc(10, 0, 0, 0); ready_is(10, 1);
    cyc(11, 1, 1, 1); cyc(12, 1, 1, 2); cyc(13, 0, 0, 3); cyc(14, 0, 0, 0);
    cyc(15, 1, 1, 1); cyc(16, 1, 1, 2); cyc(17, 0, 0, 3); cyc(18, 0, 0, 0);
    // 4 -> 5: odd divisor, 2.5 high / 2.5 low
    request(4'd5);
    cyc(19, 1, 1, 1); ready_is(19, 0); div_valid_i = 1'b0;
    cyc(20, 1, 1, 2); cyc(21, 0, 0, 3); cyc(22, 0, 0, 0); cyc(23, 0, 0, 0);
    cyc(24, 0, 0, 0); cyc(25, 0, 0, 0); ready_is(25, 1);
    cyc(26, 0, 1, 1); cyc(27, 1, 1, 2); cyc(28, 1, 1, 3); cyc(29, 0, 0, 4); cyc(30, 0, 0, 0);
    cyc(31, 0, 1, 1); cyc(32, 1, 1, 2); cyc(33, 1, 1, 3); cyc(34, 0, 0, 4); cyc(35, 0, 0, 0);
    // 5 -> 3
    request(4'd3);
    cyc(36, 0, 1, 1); div_valid_i = 1'b0;
    cyc(37, 1, 1, 2); cyc(38, 1, 1, 3); cyc(39, 0, 0, 4); cyc(40, 0, 0, 0);
    cyc(41, 0, 0, 0); cyc(42, 0, 0, 0); cyc(43, 0, 0, 0);
    cyc(44, 0, 1, 1); cyc(45, 1, 1, 2); cyc(46, 0, 0, 0);
    cyc(47, 0, 1, 1); cyc(48, 1, 1, 2); cyc(49, 0, 0, 0);
    // 3 -> 6 requested at cnt=0: the period of 3 completes first
    request(4'd6);
    cyc(50, 0, 1, 1); div_valid_i = 1'b0;
    cyc(51, 1, 1, 2); cyc(52, 0, 0, 0); cyc(53, 0, 0, 0); cyc(54, 0, 0, 0); cyc(55, 0, 0, 0);
    cyc(56, 1, 1, 1); cyc(57, 1, 1, 2); cyc(58, 1, 1, 3); cyc(59, 0, 0, 4); cyc(60, 0, 0, 5);
    cyc(61, 0, 0, 0); cyc(62, 1, 1, 1);
    // same divisor again: one-cycle round trip, waveform untouched
    request(4'd6);
    cyc(63, 1, 1, 2); ready_is(63, 0); div_valid_i = 1'b0;
    cyc(64, 1, 1, 3); ready_is(64, 1);
    cyc(65, 0, 0, 4); cyc(66, 0, 0, 5); cyc(67, 0, 0, 0); cyc(68, 1, 1, 1);
    // 6 -> 2
    request(4'd2);
    cyc(69, 1, 1, 2); div_valid_i = 1'b0;
    cyc(70, 1, 1, 3); cyc(71, 0, 0, 4); cyc(72, 0, 0, 5); cyc(73, 0, 0, 0);
    cyc(74, 0, 0, 0); cyc(75, 0, 0, 0); cyc(76, 0, 0, 0);
    cyc(77, 1, 1, 1); cyc(78, 0, 0, 0); cyc(79, 1, 1, 1); cyc(80, 0, 0, 0);
    // 2 -> bypass (divisor 0)
    request(4'd0);
    cyc(81, 1, 1, 1); ready_is(81, 0); div_valid_i = 1'b0;
    cyc(82, 0, 0, 0); ready_is(82, 0);
    cyc(83, 0, 0, 0); cyc(84, 0, 0, 0);
    cyc(85, 0, 0, 0); ready_is(85, 1);
    cyc(86, 1, 0, 0); cyc(87, 1, 0, 0);
    // bypass -> 4, then en_i low mid-period
    request(4'd4);
    cyc(88, 1, 0, 0); div_valid_i = 1'b0;
    cyc(89, 1, 0, 0); cyc(90, 0, 0, 0); cyc(91, 0, 0, 0); cyc(92, 0, 0, 0);
    cyc(93, 1, 1, 1); en_i = 1'b0;
    cyc(94, 1, 1, 2); cyc(95, 0, 0, 3); cyc(96, 0, 0, 0); cyc(97, 0, 0, 0); cyc(98, 0, 0, 0);
    en_i = 1'b1;
    cyc(99, 0, 0, 0); cyc(100, 1, 1, 1); cyc(101, 1, 1, 2); cyc(102, 0, 0, 3); cyc(103, 0, 0, 0);
    // reset while the 4 -> 5 switch sits in GATE
    request(4'd5);
    cyc(104, 1, 1, 1); div_valid_i = 1'b0;
    cyc(105, 1, 1, 2); cyc(106, 0, 0, 3); cyc(107, 0, 0, 0);
    rst_i = 1'b1;
    cyc(108, 0, 0, 0); ready_is(108, 0);
    rst_i = 1'b0;
    request(4'd2);
    cyc(109, 0, 0, 0); ready_is(109, 1);
    cyc(110, 1, 0, 0); ready_is(110, 0); div_valid_i = 1'b0;
    cyc(111, 1, 0, 0); cyc(112, 0, 0, 0); cyc(113, 0, 0, 0); cyc(114, 0, 0, 0);
    cyc(115, 1, 1, 1); cyc(116, 0, 0, 0);
    // test mode: clk_o follows clk_i while the counter keeps running
    test_mode_en_i = 1'b1;
    cyc(117, 1, 0, 1); cyc(118, 1, 0, 0);
    test_mode_en_i = 1'b0;
    cyc(119, 1, 1, 1); cyc(120, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
